// File: rtl/mac_sched_pkg.sv
// Purpose: shared constants, state encoding and lane array types for the
// MAC job scheduler and its accumulator bank.
// Ports: none (package).
package mac_sched_pkg;

    localparam int DATA_W     = 17;
    localparam int RES_W      = 32;
    localparam int IN_LANES   = 8;
    localparam int OUT_LANES  = 4;
    localparam int MAX_CHUNKS = 16;
    localparam int TIMEOUT    = 15;

    // Wide enough to hold MAX_CHUNKS itself, not just MAX_CHUNKS-1.
    localparam int CHUNK_W    = $clog2(MAX_CHUNKS + 1);
    localparam int TMO_W      = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef logic [IN_LANES-1:0][DATA_W-1:0] operand_vec_t;
    typedef logic [OUT_LANES-1:0][RES_W-1:0] result_vec_t;

endpackage

// File: rtl/mac_sched_acc.sv
// Purpose: OUT_LANES-wide accumulator bank. Adds one datapath result vector
// per add strobe, restarting from zero when the add is the first of a job.
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   clear_i        force all lanes to zero (abandoned job)
//   add_i          accumulate results_i this cycle
//   first_i        current add is the first of the job; ignore old contents
//   results_i      datapath lane sums
//   acc_o          accumulated lane sums
module mac_sched_acc
    import mac_sched_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        add_i,
    input  logic        first_i,
    input  result_vec_t results_i,
    output result_vec_t acc_o
);

    result_vec_t acc_d;
    result_vec_t acc_q;

    // Sums wrap modulo 2^RES_W; clear has priority over add.
    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (add_i) begin
            for (int i = 0; i < OUT_LANES; i++) begin
                acc_d[i] = (first_i ? RES_W'(0) : acc_q[i]) + results_i[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/mac_job_sched.sv
// Purpose: sequences dot-product jobs onto the 8-lane MAC datapath. Accepts
// one operand chunk per request handshake, issues it with a one-cycle enable,
// waits for the datapath result, accumulates across chunks and returns the
// sums on the response channel after the last chunk.
// Ports:
//   clk_i, rst_ni                        clock, async active-low reset
//   req_valid_i/req_ready_o              chunk request handshake
//   req_weights_i/req_acts_i             chunk operands
//   req_mode_i                           precision mode (first chunk only)
//   req_last_i                           final chunk of the job
//   mac_enable_o                         start pulse to datapath
//   mac_weights_o/mac_acts_o/mac_mode_o  registered datapath operands
//   mac_occupied_i                       datapath busy
//   mac_valid_i/mac_results_i            datapath result strobe and sums
//   rsp_valid_o/rsp_ready_i              response handshake
//   rsp_results_o/rsp_chunks_o/rsp_err_o accumulated sums, chunk count, error
module mac_job_sched
    import mac_sched_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  operand_vec_t       req_weights_i,
    input  operand_vec_t       req_acts_i,
    input  logic [1:0]         req_mode_i,
    input  logic               req_last_i,
    output logic               mac_enable_o,
    output operand_vec_t       mac_weights_o,
    output operand_vec_t       mac_acts_o,
    output logic [1:0]         mac_mode_o,
    input  logic               mac_occupied_i,
    input  logic               mac_valid_i,
    input  result_vec_t        mac_results_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output result_vec_t        rsp_results_o,
    output logic [CHUNK_W-1:0] rsp_chunks_o,
    output logic               rsp_err_o
);

    state_e              state_q, state_d;
    operand_vec_t        weights_q, weights_d;
    operand_vec_t        acts_q, acts_d;
    logic [1:0]          mode_q, mode_d;
    logic                last_q, last_d;
    logic                first_q, first_d;
    logic                err_q, err_d;
    logic                pend_q, pend_d;
    logic [CHUNK_W-1:0]  chunks_q, chunks_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;

    logic                req_fire;
    logic                rsp_fire;
    logic                mac_done;
    logic                timed_out;
    logic                stray;
    logic                hit_max;
    logic [CHUNK_W-1:0]  chunks_inc;
    result_vec_t         acc;

    assign req_fire   = req_valid_i && req_ready_o;
    assign rsp_fire   = rsp_valid_o && rsp_ready_i;
    assign mac_done   = (state_q == WAIT) && mac_valid_i;
    assign timed_out  = (state_q == WAIT) && !mac_valid_i && (tmo_q == TMO_W'(TIMEOUT));
    assign stray      = mac_valid_i && (state_q != WAIT);
    assign chunks_inc = chunks_q + CHUNK_W'(1);
    assign hit_max    = (chunks_inc == CHUNK_W'(MAX_CHUNKS));

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (req_fire) state_d = ISSUE;
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (mac_valid_i) begin
                    state_d = (last_q || hit_max) ? RESP : IDLE;
                end else if (timed_out) begin
                    state_d = RESP;
                end
            end
            RESP:  if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode. Response fields read zero outside RESP.
    always_comb begin
        req_ready_o   = (state_q == IDLE) && !mac_occupied_i;
        mac_enable_o  = (state_q == ISSUE);
        rsp_valid_o   = (state_q == RESP);
        rsp_results_o = (state_q == RESP) ? acc : '0;
        rsp_chunks_o  = (state_q == RESP) ? chunks_q : '0;
        rsp_err_o     = (state_q == RESP) && err_q;
    end

    // Job bookkeeping. A stray result strobe during RESP cannot touch the
    // response being presented, so it is parked in pend and handed to the
    // next job when the response handshake clears err.
    always_comb begin
        weights_d = weights_q;
        acts_d    = acts_q;
        mode_d    = mode_q;
        last_d    = last_q;
        first_d   = first_q;
        err_d     = err_q;
        pend_d    = pend_q;
        chunks_d  = chunks_q;
        tmo_d     = tmo_q;

        if (req_fire) begin
            weights_d = req_weights_i;
            acts_d    = req_acts_i;
            last_d    = req_last_i;
            if (first_q) mode_d = req_mode_i;
        end

        if (state_q == ISSUE) tmo_d = '0;
        if ((state_q == WAIT) && !mac_valid_i && !timed_out) tmo_d = tmo_q + TMO_W'(1);

        if (mac_done) begin
            chunks_d = chunks_inc;
            first_d  = 1'b0;
            if (hit_max && !last_q) err_d = 1'b1;
        end

        if (timed_out) err_d = 1'b1;

        if (stray && (state_q != RESP)) err_d  = 1'b1;
        if (stray && (state_q == RESP)) pend_d = 1'b1;

        if (rsp_fire) begin
            err_d    = pend_d;
            pend_d   = 1'b0;
            chunks_d = '0;
            first_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            weights_q <= '0;
            acts_q    <= '0;
            mode_q    <= '0;
            last_q    <= 1'b0;
            first_q   <= 1'b1;
            err_q     <= 1'b0;
            pend_q    <= 1'b0;
            chunks_q  <= '0;
            tmo_q     <= '0;
        end else begin
            weights_q <= weights_d;
            acts_q    <= acts_d;
            mode_q    <= mode_d;
            last_q    <= last_d;
            first_q   <= first_d;
            err_q     <= err_d;
            pend_q    <= pend_d;
            chunks_q  <= chunks_d;
            tmo_q     <= tmo_d;
        end
    end

    assign mac_weights_o = weights_q;
    assign mac_acts_o    = acts_q;
    assign mac_mode_o    = mode_q;

    // A timed-out job reports zero sums, so the bank is cleared on timeout.
    mac_sched_acc u_acc (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (timed_out),
        .add_i     (mac_done),
        .first_i   (first_q),
        .results_i (mac_results_i),
        .acc_o     (acc)
    );

endmodule
